// File: rtl/rr_merge_if.sv
// Bus bundle for rr_merge: packed per-master request/response vectors plus the
// single slave-side request/response pair.
interface rr_merge_if #(
  parameter int N_MASTERS = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32
);
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int RESP_W = DATA_W + 1;

  logic [N_MASTERS*REQ_W-1:0]  m_req;
  logic [N_MASTERS*RESP_W-1:0] m_resp;
  logic [REQ_W-1:0]            s_req;
  logic [RESP_W-1:0]           s_resp;

  // slave: the merge block itself; master: the requesters together with the shared slave
  modport slave  (input  m_req, s_resp, output m_resp, s_req);
  modport master (output m_req, s_resp, input  m_resp, s_req);
endinterface

// File: rtl/rr_merge.sv
// N-master to 1-slave merge with registered round-robin grant and bounded bursts.
// Optional slave-response timeout is built when MERGE_TIMEOUT_EN is defined.
module rr_merge #(
  parameter int N_MASTERS = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  rr_merge_if.slave  bus,
  output logic       err
);
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int RESP_W = DATA_W + 1;
  localparam int GW     = $clog2(N_MASTERS);
  localparam int BW     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  if (N_MASTERS < 2 || MAX_BURST < 1 || TIMEOUT < 2) begin : g_bad_params
    $error("rr_merge: illegal parameter combination");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [GW-1:0]        grant;
  logic [GW-1:0]        last;
  logic [BW-1:0]        burst_cnt;
  logic [N_MASTERS-1:0] vld;
  logic                 s_ready;
  logic                 tmo;
  logic                 others;
  logic                 found;
  logic [GW-1:0]        pick;
  logic [BW-1:0]        burst_nxt;
  int                   idx;

  assign s_ready = bus.s_resp[0];

  always_comb begin
    vld = '0;
    for (int i = 0; i < N_MASTERS; i++) vld[i] = bus.m_req[i*REQ_W + REQ_W - 1];
  end

  // last keeps the grant while its burst budget lasts or nobody else is waiting
  always_comb begin
    others = 1'b0;
    for (int i = 0; i < N_MASTERS; i++)
      if (i != int'(last) && vld[i]) others = 1'b1;
    pick  = last;
    found = vld[last] && ((int'(burst_cnt) < MAX_BURST - 1) || !others);
    idx   = 0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx = (int'(last) + k) % N_MASTERS;
      if (!found && vld[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
    if (pick == last)
      burst_nxt = (int'(burst_cnt) >= MAX_BURST - 1) ? burst_cnt : burst_cnt + BW'(1);
    else
      burst_nxt = '0;
  end

`ifdef MERGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] to_cnt;

  assign tmo = (state == BUSY) && !s_ready && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              to_cnt <= '0;
    else if (state == IDLE)  to_cnt <= '0;
    else if (!s_ready)       to_cnt <= to_cnt + TW'(1);
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      last      <= GW'(N_MASTERS - 1);
      burst_cnt <= BW'(MAX_BURST - 1);
    end else begin
      case (state)
        IDLE: if (|vld) begin
          grant     <= pick;
          last      <= pick;
          burst_cnt <= burst_nxt;
          state     <= BUSY;
        end
        BUSY: if (s_ready || !vld[grant] || tmo) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request/response routing is a pure mux on the registered grant
  always_comb begin
    bus.s_req  = '0;
    bus.m_resp = '0;
    err        = 1'b0;
    if (state == BUSY) begin
      bus.s_req = bus.m_req[int'(grant)*REQ_W +: REQ_W];
      bus.m_resp[int'(grant)*RESP_W +: RESP_W] = bus.s_resp;
      if (tmo) begin
        bus.s_req[REQ_W-1] = 1'b0;
        bus.m_resp[int'(grant)*RESP_W +: RESP_W] = RESP_W'(1);
        err = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rr_merge.sv
// Directed bench for rr_merge: 2-master instance for transfer/fairness/abort/timeout,
// 4-master instance for round-robin wrap-around.
module tb_rr_merge;
  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int REQ_W  = 1 + AW + DW + DW / 8;
  localparam int RESP_W = DW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic err2, err4;

  rr_merge_if #(.N_MASTERS(2), .DATA_W(DW), .ADDR_W(AW)) if2 ();
  rr_merge_if #(.N_MASTERS(4), .DATA_W(DW), .ADDR_W(AW)) if4 ();

  rr_merge #(.N_MASTERS(2), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(4), .TIMEOUT(8)) u_n2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave), .err(err2));
  rr_merge #(.N_MASTERS(4), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(4), .TIMEOUT(8)) u_n4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave), .err(err4));

  int tests = 0;
  int fails = 0;

  logic [REQ_W-1:0]      rq_a, rq_b, rq_c, rq_d, zreq;
  logic [RESP_W-1:0]     rsp, zresp;
  logic [2*RESP_W-1:0]   exp2;
  int                    exp_g [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    rq_a  = {1'b1, 32'h0000_0100, 32'h1111_1111, 4'h3};
    rq_b  = {1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF};
    rq_c  = {1'b1, 32'h0000_0200, 32'h2222_2222, 4'hC};
    rq_d  = {1'b1, 32'h0000_0300, 32'h3333_3333, 4'h1};
    zreq  = '0;
    rsp   = {32'hCAFE_0001, 1'b1};
    zresp = '0;
    rst_n = 1'b0;
    if2.m_req = '0; if2.s_resp = '0;
    if4.m_req = '0; if4.s_resp = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_s_req", if2.s_req, 0);
    check("rst_m_resp", if2.m_resp, 0);
    check("rst_err", err2, 0);
    check("rst_s_req4", if4.s_req, 0);
    @(negedge clk); rst_n = 1'b1;

    // Single transfer from master 1, ready two cycles after grant
    @(negedge clk); if2.m_req = {rq_b, zreq}; #1;
    check("single_t_idle", if2.s_req, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) if2.s_resp = rsp;
      #1;
      exp2 = '0;
      if (k == 2) exp2 = {rsp, zresp};
      check("single_s_req", if2.s_req, rq_b);
      check("single_m_resp", if2.m_resp, exp2);
    end
    @(negedge clk); #1;
    check("single_idle_s_req", if2.s_req, 0);
    check("single_idle_m_resp", if2.m_resp, 0);
    if2.m_req = '0; if2.s_resp = '0;

    // Reset asserted in the middle of a BUSY cycle
    @(negedge clk); if2.m_req = {rq_b, rq_a};
    @(negedge clk); if2.s_resp = rsp; #1;
    check("pre_rst_s_req", if2.s_req, rq_a);
    check("pre_rst_m_resp", if2.m_resp, {zresp, rsp});
    #1 rst_n = 1'b0;
    #1;
    check("busy_rst_s_req", if2.s_req, 0);
    check("busy_rst_m_resp", if2.m_resp, 0);
    check("busy_rst_err", err2, 0);
    @(negedge clk); rst_n = 1'b1;

    // Both masters continuously valid, slave ready immediately
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); #1;
      check("fair_grant", if2.s_req, (exp_g[i] == 1) ? rq_b : rq_a);
      check("fair_resp", if2.m_resp, (exp_g[i] == 1) ? {rsp, zresp} : {zresp, rsp});
      @(negedge clk); #1;
      check("fair_bubble", if2.s_req, 0);
      check("fair_bubble_resp", if2.m_resp, 0);
    end

    // Lone master 0 for 6 transactions
    if2.m_req = {zreq, rq_a};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      check("lone_grant", if2.s_req, rq_a);
      @(negedge clk); #1;
      check("lone_bubble", if2.s_req, 0);
    end
    check("lone_burst_sat", u_n2.burst_cnt, 3);
    if2.m_req = {rq_b, rq_a};
    @(negedge clk); #1;
    check("exhausted_grant", if2.s_req, rq_b);
    @(negedge clk); #1;
    check("exhausted_bubble", if2.s_req, 0);
    if2.m_req = {zreq, rq_a}; if2.s_resp = '0;

    // Abort: granted master drops valid before ready
    @(negedge clk); #1;
    check("abort_busy", if2.s_req, rq_a);
    if2.m_req = {rq_b, zreq}; #1;
    check("abort_valid_low", if2.s_req, 0);
    @(negedge clk); #1;
    check("abort_idle", if2.s_req, 0);
    @(negedge clk); #1;
    check("after_abort_grant", if2.s_req, rq_b);

`ifdef MERGE_TIMEOUT_EN
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk); #1;
      if (c < 8) begin
        check("to_wait_err", err2, 0);
        check("to_wait_s_req", if2.s_req, rq_b);
      end else begin
        check("to_err", err2, 1);
        check("to_m_resp", if2.m_resp, {RESP_W'(1), zresp});
        check("to_s_req", if2.s_req, {1'b0, rq_b[REQ_W-2:0]});
      end
    end
    @(negedge clk); #1;
    check("to_idle_s_req", if2.s_req, 0);
    check("to_idle_err", err2, 0);
    if2.m_req = '0;
`else
    for (int c = 0; c < 110; c++) begin
      @(negedge clk); #1;
      check("hold_s_req", if2.s_req, rq_b);
      check("hold_err", err2, 0);
      check("hold_m_resp", if2.m_resp, 0);
    end
    if2.m_req = '0;
    @(negedge clk); #1;
    check("hold_release_idle", if2.s_req, 0);
`endif

    // Wrap-around on the 4-master instance from reset state (last=3, burst exhausted)
    @(negedge clk); if4.m_req = {rq_d, zreq, rq_b, zreq}; if4.s_resp = rsp; #1;
    check("wrap_idle", if4.s_req, 0);
    @(negedge clk); #1;
    check("wrap_grant1", if4.s_req, rq_b);
    check("wrap_resp1", if4.m_resp, {zresp, zresp, rsp, zresp});
    if4.m_req = {rq_d, rq_c, zreq, zreq};
    @(negedge clk); #1;
    check("wrap_bubble", if4.s_req, 0);
    @(negedge clk); #1;
    check("wrap_grant2", if4.s_req, rq_c);
    check("wrap_resp2", if4.m_resp, {zresp, rsp, zresp, zresp});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_merge.md
# rr_merge

Parametrised N-master to 1-slave native-bus merge with registered grant, round-robin arbitration and a bounded-burst fairness rule. It sits in the interconnect between several requesters (CPU, DMA, accelerator engines) and one shared slave (memory controller, cache or peripheral bus). It is the fair, transaction-locking successor of the priority-pointer merge; an optional slave timeout releases a hung transaction.

## Interface
- `N_MASTERS`, 2: number of master ports, ≥2.
- `DATA_W`, 32: data width; `DATA_W/8` strobe bits.
- `ADDR_W`, 32: address width.
- `MAX_BURST`, 4: maximum consecutive grants to one master while another master is waiting, ≥1.
- `TIMEOUT`, 1024: slave-response timeout in cycles, ≥2; used only with `MERGE_TIMEOUT_EN`.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `m_req` in `N_MASTERS*REQ_W`: per-master `{valid, addr[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}`; master i occupies slice i.
- `m_resp` out `N_MASTERS*RESP_W`: per-master `{rdata[DATA_W], ready}`.
- `s_req` out `REQ_W`: request to the slave.
- `s_resp` in `RESP_W`: slave response; `ready` is a one-cycle completion pulse.
- `err` out 1: one-cycle timeout pulse; constant 0 when the timeout feature is compiled out.

## Operation
- State registers: `state` (IDLE/BUSY), `grant` (`$clog2(N_MASTERS)` bits), `last` (last granted index), `burst_cnt` (`$clog2(MAX_BURST)` bits, min 1), and `to_cnt` when enabled.
- Reset values: IDLE, `grant`=0, `last`=N_MASTERS-1, `burst_cnt`=MAX_BURST-1 (exhausted), `to_cnt`=0. Outputs `s_req`=0, `m_resp`=0 and `err`=0.
- IDLE, no master valid: stay in IDLE with all outputs 0. A slave `ready` in this state is ignored.
- IDLE, any master valid: pick a master, then load `grant` and go to BUSY.
  - Pick `last` if it is valid and either `burst_cnt` < MAX_BURST-1 or no other master is valid.
  - Otherwise, search round-robin from `last+1`, wrapping modulo N_MASTERS, and pick the first valid master.
- Burst counting: if the new grant equals `last`, increment `burst_cnt`, saturating at MAX_BURST-1. Otherwise set `burst_cnt`=0. Set `last`=grant.
- With MAX_BURST=1, arbitration is pure round-robin.
- BUSY routing: `s_req` = `m_req[grant]`, combinationally. `m_resp[grant]` = `s_resp`; all other `m_resp` slices are 0.
- BUSY completion: `s_resp.ready`=1 completes the transaction; go to IDLE next cycle.
- BUSY abort: if master `grant` drops `valid` before `ready`, go to IDLE next cycle. No response is generated; the slave sees valid low that cycle.
- Transfers are never interleaved: the grant is held until completion, abort or timeout.
- Reset during BUSY: the grant drops immediately and asynchronously; `s_req.valid`=0 with no clock required.

## Timing
- Cycle t: master i asserts valid with the block in IDLE.
- Cycle t+1: BUSY with `grant`=i; `s_req` carries master i's request.
- Slave `ready` at cycle t+1+k (k≥0): `m_resp[i].ready`=1 in the same cycle, with zero response latency.
- The block is in IDLE at t+2+k.
- Minimum 2 cycles per transaction, with one arbitration bubble between transactions.
- Request path is combinational mux only; the decision path is registered, keeping grant selection off the slave timing path.

## Configuration
- `MERGE_TIMEOUT_EN` defined:
  - `to_cnt` clears on entering BUSY and increments each BUSY cycle without `ready`.
  - When `to_cnt` reaches TIMEOUT-1 without `ready`, the block drives `m_resp[grant]` = `{rdata=0, ready=1}` and `err`=1 for that cycle, forces `s_req.valid`=0, and goes to IDLE next cycle.
  - If `ready` arrives in the same cycle as the timeout, it is a normal completion and `err`=0.
- Not defined: no counter is built, `err` is tied to 0, and BUSY waits indefinitely for `ready`.

## Test plan
- Reset: assert `rst_n`=0 mid-BUSY -> `s_req`=0, `m_resp`=0 and `err`=0 immediately; after release, the first request from master 0 is granted before master 1.
- Single transfer: master 1 writes addr 0x10, wdata 0xA5A5A5A5, wstrb 0xF; slave ready 2 cycles after grant -> `s_req` matches from t+1, `m_resp[1].ready` in the ready cycle, `m_resp[0]`=0 throughout, IDLE next cycle.
- Fairness: masters 0 and 1 continuously valid, MAX_BURST=4, slave ready immediately -> grant sequence 0,0,0,0,1,1,1,1,0,… with one IDLE cycle between transactions.
- Lone master: only master 0 valid for 6 transactions, MAX_BURST=4 -> all 6 granted to 0 and `burst_cnt` saturates at 3.
- Wrap-around: N_MASTERS=4, `last`=3, `burst_cnt` exhausted, masters 1 and 3 valid -> grant 1; then master 2 becomes valid -> next grant 2.
- Timeout (MERGE_TIMEOUT_EN, TIMEOUT=8): slave never ready -> in the 8th BUSY cycle `m_resp[grant]` = `{0, 1}` and `err`=1 for 1 cycle, then IDLE. Without the macro -> BUSY is held for 100+ cycles with `err`=0.
